// File: rtl/max7219_chain_driver_if.sv
// Host-side bus of the MAX7219 chain driver: framebuffer write port, display
// controls and the serial/status outputs toward the matrix chain.
interface max7219_chain_driver_if #(
  parameter int NUM_DEV = 4
);
  localparam int AW = $clog2(NUM_DEV) + 3;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [3:0]    intensity;
  logic          display_active;
  logic          DIN;
  logic          CS;
  logic          SCLK;
  logic          init_done;
  logic          frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, intensity, display_active,
    input  DIN, CS, SCLK, init_done, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, intensity, display_active,
    output DIN, CS, SCLK, init_done, frame_done
  );
endinterface

// File: rtl/max7219_chain_driver.sv
// MAX7219 daisy-chain driver: broadcast init, continuous row refresh with
// intensity updates, internal framebuffer and bit-serial shifter.
module max7219_chain_driver #(
  parameter int NUM_DEV    = 4,
  parameter int CLK_DIV    = 1,
  parameter int SCAN_LIMIT = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  max7219_chain_driver_if.slave  bus
);

  // state            | meaning
  // ST_INIT          | sending the five broadcast init transactions
  // ST_REFRESH       | sending one row per transaction for every device
  // ST_INTENSITY_UPD | a broadcast 0x0A transaction is in flight
  typedef enum logic [1:0] {ST_INIT, ST_REFRESH, ST_INTENSITY_UPD} state_t;

  localparam int AW = $clog2(NUM_DEV) + 3;
  localparam int SW = 16 * NUM_DEV;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(SW);

  localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD  = BW'(SW - 1);

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            sclk_q, sclk_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [HW-1:0]   half_q, half_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [2:0]      step_q, step_d;
  logic [2:0]      row_q, row_d;
  logic [3:0]      shadow_q, shadow_d;
  logic            init_done_q, init_done_d;
  logic            frame_done_q, frame_done_d;

  logic [SW-1:0]   row_frame;
  logic [7:0]      row_addr;
  logic [15:0]     word16;

  assign row_addr = {5'b00000, row_q} + 8'd1;

  // Device g occupies bits [16g +: 16]; the top word reaches the far end of the chain.
  for (genvar g = 0; g < NUM_DEV; g++) begin : g_dev
    logic [7:0] rows_q [8];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int r = 0; r < 8; r++) rows_q[r] <= 8'h00;
      end else if (bus.wr_en && ((bus.wr_addr >> 3) == AW'(g))) begin
        rows_q[bus.wr_addr[2:0]] <= bus.wr_data;
      end
    end

    assign row_frame[16*g +: 16] = {row_addr, bus.display_active ? rows_q[row_q] : 8'h00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      busy_q       <= 1'b0;
      sclk_q       <= 1'b0;
      sr_q         <= '0;
      half_q       <= HALF_LOAD;
      bit_q        <= BIT_LOAD;
      gap_q        <= GAP_LOAD;
      step_q       <= 3'd0;
      row_q        <= 3'd0;
      shadow_q     <= 4'hF;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      sclk_q       <= sclk_d;
      sr_q         <= sr_d;
      half_q       <= half_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      step_q       <= step_d;
      row_q        <= row_d;
      shadow_q     <= shadow_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    sclk_d       = sclk_q;
    sr_d         = sr_q;
    half_d       = half_q;
    bit_d        = bit_q;
    gap_d        = gap_q;
    step_d       = step_q;
    row_d        = row_q;
    shadow_d     = shadow_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    word16       = 16'h0000;

    if (!busy_q) begin
      if (gap_q != '0) begin
        gap_d = gap_q - 1'b1;
      end else begin
        // Latch point: the whole transaction is captured on the CS-fall edge.
        busy_d = 1'b1;
        sclk_d = 1'b0;
        half_d = HALF_LOAD;
        bit_d  = BIT_LOAD;
        if (state_q == ST_INIT) begin
          case (step_q)
            3'd0:    word16 = 16'h0C01;
            3'd1:    word16 = 16'h0900;
            3'd2:    word16 = {8'h0B, 8'(SCAN_LIMIT)};
            3'd3: begin
              word16   = {8'h0A, 4'h0, bus.intensity};
              shadow_d = bus.intensity;
            end
            default: word16 = 16'h0F00;
          endcase
          step_d = step_q + 3'd1;
          sr_d   = {NUM_DEV{word16}};
        end else if (bus.intensity != shadow_q) begin
          word16   = {8'h0A, 4'h0, bus.intensity};
          shadow_d = bus.intensity;
          state_d  = ST_INTENSITY_UPD;
          sr_d     = {NUM_DEV{word16}};
        end else begin
          sr_d = row_frame;
        end
      end
    end else if (half_q != '0) begin
      half_d = half_q - 1'b1;
    end else begin
      half_d = HALF_LOAD;
      if (!sclk_q) begin
        sclk_d = 1'b1;
      end else begin
        sclk_d = 1'b0;
        if (bit_q != '0) begin
          bit_d = bit_q - 1'b1;
          sr_d  = {sr_q[SW-2:0], 1'b0};
        end else begin
          // Final SCLK fall: CS rises here and the inter-transaction gap begins.
          busy_d = 1'b0;
          gap_d  = GAP_LOAD;
          case (state_q)
            ST_INIT: begin
              if (step_q == 3'd5) begin
                init_done_d = 1'b1;
                state_d     = ST_REFRESH;
              end
            end
            ST_REFRESH: begin
              row_d = row_q + 3'd1;
              if (row_q == 3'd7) frame_done_d = 1'b1;
            end
            default: state_d = ST_REFRESH;
          endcase
        end
      end
    end
  end

  assign bus.CS         = ~busy_q;
  assign bus.SCLK       = sclk_q;
  assign bus.DIN        = busy_q & sr_q[SW-1];
  assign bus.init_done  = init_done_q;
  assign bus.frame_done = frame_done_q;

endmodule
